// File: rtl/swi_reader_pkg.sv
// Shared types and default sizing for the switch reader.
package swi_reader_pkg;

  localparam int unsigned NBITS_DEFAULT           = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  // Wide enough for the largest legal debounce length (255).
  localparam int unsigned CNT_W                   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } evt_state_t;

endpackage : swi_reader_pkg

// File: rtl/swi_debounce_bit.sv
// Per-switch two-flop synchronizer, stability counter and debounced level flop.
module swi_debounce_bit
  import swi_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk_2,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic upd_c
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             diff;

  assign diff  = sync_q[1] ^ stable;
  // Fires on the edge where the synchronized level has differed long enough.
  assign upd_c = diff & (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk_2) begin
    if (reset) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (!diff) begin
        cnt_q <= '0;
      end else if (upd_c) begin
        stable <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : swi_debounce_bit

// File: rtl/swi_reader.sv
// Debounced switch bank with optional edge pulses and a valid/ready change-event port.
// Edge pulse logic is built only when SWI_READER_EDGE_EN is defined.
module swi_reader
  import swi_reader_pkg::*;
#(
  parameter int unsigned NBITS           = NBITS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [NBITS-1:0] swi_raw,
  output logic [NBITS-1:0] swi_stable,
  output logic [NBITS-1:0] swi_rise,
  output logic [NBITS-1:0] swi_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [NBITS-1:0] evt_data,
  output logic             evt_overrun
);

  logic [NBITS-1:0] upd_c;
  logic [NBITS-1:0] stable_nxt;
  logic             change;
  logic             hs;

  evt_state_t       state_q;
  evt_state_t       state_nxt;
  logic [NBITS-1:0] data_nxt;
  logic             ovr_nxt;

  for (genvar i = 0; i < NBITS; i++) begin : g_bit
    swi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_2 (clk_2),
      .reset (reset),
      .raw   (swi_raw[i]),
      .stable(swi_stable[i]),
      .upd_c (upd_c[i])
    );
  end

  // Value swi_stable takes after this edge; lets the event path track it with no lag.
  assign stable_nxt = swi_stable ^ upd_c;
  assign change     = |upd_c;
  assign hs         = evt_valid & evt_ready;

`ifdef SWI_READER_EDGE_EN
  always_ff @(posedge clk_2) begin
    if (reset) begin
      swi_rise <= '0;
      swi_fall <= '0;
    end else begin
      swi_rise <= upd_c & ~swi_stable;
      swi_fall <= upd_c & swi_stable;
    end
  end
`else
  assign swi_rise = '0;
  assign swi_fall = '0;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q     <= IDLE;
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_overrun <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      evt_valid   <= (state_nxt == PEND);
      evt_data    <= data_nxt;
      evt_overrun <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    data_nxt  = evt_data;
    ovr_nxt   = evt_overrun;
    case (state_q)
      IDLE: begin
        if (change) begin
          data_nxt  = stable_nxt;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (hs) begin
          if (change) begin
            data_nxt = stable_nxt;
          end else begin
            state_nxt = IDLE;
          end
        end else if (change) begin
          // Stalled consumer: keep the pending snapshot, remember that one was lost.
          ovr_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule : swi_reader

// File: tb/tb_swi_reader.sv
// Directed self-checking bench for swi_reader (NBITS=8, DEBOUNCE_CYCLES=4).
module tb_swi_reader;

`ifdef SWI_READER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk_2;
  logic       reset;
  logic [7:0] swi_raw;
  logic [7:0] swi_stable;
  logic [7:0] swi_rise;
  logic [7:0] swi_fall;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       evt_overrun;

  int unsigned n_checks;
  int unsigned n_fail;

  swi_reader #(
    .NBITS          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .swi_raw    (swi_raw),
    .swi_stable (swi_stable),
    .swi_rise   (swi_rise),
    .swi_fall   (swi_fall),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .evt_overrun(evt_overrun)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  function automatic logic [7:0] edge_exp(input logic [7:0] v);
    return EDGE_EN ? v : 8'h00;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    swi_raw   = 8'h00;
    evt_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    swi_raw   = 8'h00;
    evt_ready = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_stable", 32'(swi_stable), 32'h00);
    check_eq("rst_rise", 32'(swi_rise), 32'h00);
    check_eq("rst_fall", 32'(swi_fall), 32'h00);
    check_eq("rst_valid", 32'(evt_valid), 32'h0);
    check_eq("rst_data", 32'(evt_data), 32'h00);
    check_eq("rst_ovr", 32'(evt_overrun), 32'h0);

    // Basic debounce: 0x05 visible after edge 5
    swi_raw = 8'h05;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("lat_stable_early", 32'(swi_stable), 32'h00);
      check_eq("lat_valid_early", 32'(evt_valid), 32'h0);
    end
    tick();
    check_eq("lat_stable", 32'(swi_stable), 32'h05);
    check_eq("lat_rise", 32'(swi_rise), 32'(edge_exp(8'h05)));
    check_eq("lat_fall", 32'(swi_fall), 32'h00);
    check_eq("lat_valid", 32'(evt_valid), 32'h1);
    check_eq("lat_data", 32'(evt_data), 32'h05);
    check_eq("lat_ovr", 32'(evt_overrun), 32'h0);
    tick();
    check_eq("rise_one_cycle", 32'(swi_rise), 32'h00);
    check_eq("hold_stable", 32'(swi_stable), 32'h05);
    check_eq("hold_valid", 32'(evt_valid), 32'h1);

    // Stalled consumer plus change: data holds, overrun sets
    swi_raw = 8'h01;
    repeat (6) tick();
    check_eq("ovr_stable", 32'(swi_stable), 32'h01);
    check_eq("ovr_fall", 32'(swi_fall), 32'(edge_exp(8'h04)));
    check_eq("ovr_data_hold", 32'(evt_data), 32'h05);
    check_eq("ovr_flag", 32'(evt_overrun), 32'h1);
    check_eq("ovr_valid", 32'(evt_valid), 32'h1);
    evt_ready = 1'b1;
    tick();
    check_eq("hs_valid_drop", 32'(evt_valid), 32'h0);
    check_eq("hs_ovr_sticky", 32'(evt_overrun), 32'h1);
    evt_ready = 1'b0;
    tick();
    check_eq("idle_valid", 32'(evt_valid), 32'h0);
    check_eq("idle_ovr_sticky", 32'(evt_overrun), 32'h1);

    // Handshake coinciding with a change reloads the snapshot
    do_reset();
    swi_raw = 8'h05;
    repeat (6) tick();
    check_eq("rl_valid0", 32'(evt_valid), 32'h1);
    check_eq("rl_data0", 32'(evt_data), 32'h05);
    swi_raw = 8'h04;
    repeat (5) tick();
    check_eq("rl_stable_pre", 32'(swi_stable), 32'h05);
    check_eq("rl_data_pre", 32'(evt_data), 32'h05);
    evt_ready = 1'b1;
    tick();
    check_eq("rl_stable", 32'(swi_stable), 32'h04);
    check_eq("rl_data", 32'(evt_data), 32'h04);
    check_eq("rl_valid", 32'(evt_valid), 32'h1);
    check_eq("rl_fall", 32'(swi_fall), 32'(edge_exp(8'h01)));
    check_eq("rl_ovr", 32'(evt_overrun), 32'h0);
    tick();
    check_eq("rl_done_valid", 32'(evt_valid), 32'h0);
    evt_ready = 1'b0;

    // Glitch of 3 cycles is rejected
    do_reset();
    swi_raw = 8'h08;
    repeat (3) tick();
    swi_raw = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("glitch_stable", 32'(swi_stable), 32'h00);
      check_eq("glitch_rise", 32'(swi_rise), 32'h00);
      check_eq("glitch_valid", 32'(evt_valid), 32'h0);
    end

    // Pulse of exactly 4 cycles is accepted, then its release too
    swi_raw = 8'h08;
    repeat (4) tick();
    swi_raw = 8'h00;
    tick();
    check_eq("p4_stable_pre", 32'(swi_stable), 32'h00);
    tick();
    check_eq("p4_stable", 32'(swi_stable), 32'h08);
    check_eq("p4_rise", 32'(swi_rise), 32'(edge_exp(8'h08)));
    check_eq("p4_data", 32'(evt_data), 32'h08);
    repeat (6) tick();
    check_eq("p4_release", 32'(swi_stable), 32'h00);
    check_eq("p4_data_hold", 32'(evt_data), 32'h08);
    check_eq("p4_ovr", 32'(evt_overrun), 32'h1);

    // Reset mid-count discards progress
    do_reset();
    swi_raw = 8'hFF;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("mid_rst_stable", 32'(swi_stable), 32'h00);
    check_eq("mid_rst_valid", 32'(evt_valid), 32'h0);
    check_eq("mid_rst_data", 32'(evt_data), 32'h00);
    check_eq("mid_rst_rise", 32'(swi_rise), 32'h00);
    check_eq("mid_rst_ovr", 32'(evt_overrun), 32'h0);
    reset = 1'b0;
    repeat (5) tick();
    check_eq("rel_stable_early", 32'(swi_stable), 32'h00);
    tick();
    check_eq("rel_stable", 32'(swi_stable), 32'hFF);
    check_eq("rel_valid", 32'(evt_valid), 32'h1);
    check_eq("rel_data", 32'(evt_data), 32'hFF);
    check_eq("rel_rise", 32'(swi_rise), 32'(edge_exp(8'hFF)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_swi_reader

// File: doc/swi_reader.md
SWI_READER -- requirements
Module: swi_reader

Interface
REQ-001 Parameter NBITS, default 8, number of switch inputs handled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed to accept a change; legal range 1..255.
REQ-003 clk_2  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 swi_raw  input  NBITS  asynchronous switch levels (board SWI).
REQ-006 swi_stable  output  NBITS  debounced switch levels.
REQ-007 swi_rise  output  NBITS  one-cycle pulse per bit on a stable 0->1 change.
REQ-008 swi_fall  output  NBITS  one-cycle pulse per bit on a stable 1->0 change.
REQ-009 evt_valid  output  1  change event pending for the consumer.
REQ-010 evt_ready  input  1  consumer accepts the event when high together with evt_valid.
REQ-011 evt_data  output  NBITS  snapshot of swi_stable captured at the event.
REQ-012 evt_overrun  output  1  sticky flag: a change occurred while an event was stalled.

Function
REQ-013 Each bit of swi_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each bit has its own counter: cleared whenever the synchronized bit equals swi_stable; otherwise incremented each cycle.
REQ-015 After DEBOUNCE_CYCLES consecutive differing cycles, swi_stable[i] SHALL take the synchronized value and the counter SHALL clear.
REQ-016 Latency: a raw level held from edge 0 SHALL appear on swi_stable after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 cycles.
REQ-017 A synchronized pulse shorter than DEBOUNCE_CYCLES cycles SHALL never change swi_stable and SHALL leave the counter at 0 once it ends.
REQ-018 swi_rise/swi_fall SHALL be registered and high exactly in the cycle in which the new swi_stable value is first visible.
REQ-019 Event FSM states: IDLE (evt_valid=0) and PEND (evt_valid=1).
REQ-020 IDLE: on any swi_stable change, load evt_data with the new swi_stable and go to PEND.
REQ-021 PEND, handshake, no change: go to IDLE.
REQ-022 PEND, handshake and change in the same cycle: reload evt_data with the new value and stay in PEND.
REQ-023 PEND, no handshake, change: evt_data SHALL hold, evt_overrun SHALL set, state stays PEND.
REQ-024 evt_data SHALL never change while evt_valid=1 and evt_ready=0.
REQ-025 evt_overrun clears only on reset.

Reset
REQ-026 While reset=1 at a clock edge: synchronizers, counters, swi_stable, swi_rise, swi_fall, evt_data and evt_overrun SHALL go to 0, evt_valid SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-027 Reset mid-count or mid-event SHALL discard all progress; switches high at release SHALL produce changes DEBOUNCE_CYCLES+2 cycles after release.

Configuration
REQ-028 Macro SWI_READER_EDGE_EN defined: swi_rise/swi_fall SHALL behave per REQ-018.
REQ-029 Macro SWI_READER_EDGE_EN undefined: no edge logic is built, and swi_rise/swi_fall SHALL be tied to constant 0. The event path is unaffected.

Structure
REQ-030 Package swi_reader_pkg SHALL hold the FSM state enum typedef (IDLE, PEND) and the default NBITS/DEBOUNCE_CYCLES constants.
REQ-031 Sub-module swi_debounce_bit SHALL implement the per-bit synchronizer, counter and stable flop. It is instantiated NBITS times via generate.

Verification (NBITS=8, DEBOUNCE_CYCLES=4, macro defined)
REQ-032 Reset, swi_raw=8'h00 then 8'h05 held -> swi_stable=8'h05 after 6 cycles; swi_rise=8'h05 for 1 cycle; evt_valid=1 with evt_data=8'h05.
REQ-033 swi_raw[3] high for 3 cycles only -> swi_stable stays 8'h00, no pulses, evt_valid stays 0.
REQ-034 evt_ready=0, swi_raw 8'h05 then 8'h01 -> evt_data holds 8'h05 and evt_overrun=1; then evt_ready=1 -> one handshake, evt_valid=0 next cycle, evt_overrun stays 1.
REQ-035 evt_ready=1 in the same cycle as swi_stable changes 8'h05->8'h04 -> evt_data=8'h04, evt_valid stays 1, swi_fall=8'h01 pulse.
REQ-036 swi_raw=8'hFF, reset pulsed 1 cycle at cycle 3 -> all outputs 0; swi_stable=8'hFF 6 cycles after release.
REQ-037 Macro undefined, repeat REQ-032 -> swi_rise=swi_fall=8'h00 always; evt_data=8'h05 as before.
